// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stall requests, schedules multi-cycle EX ops and
// sequences one-cycle exception flushes with a registered redirect PC.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter logic [31:0] ERET_CODE  = 32'h0000_000e
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic        ex_multi_start_i,
  input  logic [5:0]  ex_multi_len_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [31:0] stall_cycles_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        flush_q, flush_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        exc_s;
  logic        ex_busy_s;

  assign exc_s     = (excepttype_i != 32'd0) && (state_q != FLUSH);
  assign ex_busy_s = stallreq_from_ex || (state_q == COUNT) ||
                     (ex_multi_start_i && (ex_multi_len_i >= 6'd2));

  // Stall vector priority; forced quiet while reset is asserted.
  always_comb begin
    stall_o = 6'b000000;
    if (rst) begin
      stall_o = 6'b000000;
    end else if (state_q == FLUSH) begin
      stall_o = 6'b000000;
    end else if (exc_s) begin
      stall_o = 6'b111111;
    end else if (stallreq_from_mem) begin
      stall_o = 6'b011111;
    end else if (ex_busy_s) begin
      stall_o = 6'b001111;
    end else if (stallreq_from_id) begin
      stall_o = 6'b000111;
    end else begin
      stall_o = 6'b000000;
    end
  end

  // Next-state logic for the controller FSM, op counter and redirect PC.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    new_pc_d = new_pc_q;
    case (state_q)
      IDLE: begin
        if (exc_s) begin
          state_d  = FLUSH;
          cnt_d    = 6'd0;
          new_pc_d = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
        end else if (ex_multi_start_i && (ex_multi_len_i >= 6'd3)) begin
          state_d = COUNT;
          cnt_d   = ex_multi_len_i - 6'd2;
        end else begin
          state_d = IDLE;
        end
      end
      COUNT: begin
        if (exc_s) begin
          state_d  = FLUSH;
          cnt_d    = 6'd0;
          new_pc_d = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
        end else if (cnt_q == 6'd1) begin
          // The MEM stall does not pause the op; the counter keeps running.
          state_d = IDLE;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      FLUSH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 6'd0;
      end
    endcase
    flush_d = (state_d == FLUSH);
  end

  // Saturating count of cycles with the PC stalled.
  always_comb begin
    if (stall_o[0] && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 6'd0;
      flush_q     <= 1'b0;
      new_pc_q    <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      flush_q     <= flush_d;
      new_pc_q    <= new_pc_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign flush_o        = flush_q;
  assign new_pc_o       = new_pc_q;
  assign stall_cycles_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl with hand-computed expectations.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic        stallreq_from_mem;
  logic        ex_multi_start_i;
  logic [5:0]  ex_multi_len_i;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic [31:0] stall_cycles_o;

  int checks_cnt;
  int fail_cnt;
  logic [31:0] exp_sc;

  pipe_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_from_id  (stallreq_from_id),
    .stallreq_from_ex  (stallreq_from_ex),
    .stallreq_from_mem (stallreq_from_mem),
    .ex_multi_start_i  (ex_multi_start_i),
    .ex_multi_len_i    (ex_multi_len_i),
    .excepttype_i      (excepttype_i),
    .cp0_epc_i         (cp0_epc_i),
    .stall_o           (stall_o),
    .flush_o           (flush_o),
    .new_pc_o          (new_pc_o),
    .stall_cycles_o    (stall_cycles_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt = checks_cnt + 1;
    if (obs !== exp) begin
      fail_cnt = fail_cnt + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the bench's own counter model follows the expected stall bit.
  task automatic tick(input logic stalled);
    if (stalled && exp_sc != 32'hFFFF_FFFF) exp_sc = exp_sc + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    stallreq_from_id  = 1'b0;
    stallreq_from_ex  = 1'b0;
    stallreq_from_mem = 1'b0;
    ex_multi_start_i  = 1'b0;
    ex_multi_len_i    = 6'd0;
    excepttype_i      = 32'd0;
  endtask

  initial begin
    checks_cnt = 0;
    fail_cnt   = 0;
    exp_sc     = 32'd0;
    cp0_epc_i  = 32'd0;
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    settle();
    check_eq("rst_stall", {26'd0, stall_o}, 32'h0000_0000);
    check_eq("rst_flush", {31'd0, flush_o}, 32'd0);
    check_eq("rst_newpc", new_pc_o, 32'd0);
    check_eq("rst_sc", stall_cycles_o, 32'd0);

    // 1: ID bubble for one cycle
    stallreq_from_id = 1'b1; settle();
    check_eq("t1_stall", {26'd0, stall_o}, 32'h0000_0007);
    tick(1'b1);
    stallreq_from_id = 1'b0; settle();
    check_eq("t1_stall_next", {26'd0, stall_o}, 32'h0000_0000);
    check_eq("t1_sc", stall_cycles_o, 32'd1);
    tick(1'b0);

    // 2: multi-cycle op L=5 -> four stall cycles
    ex_multi_start_i = 1'b1; ex_multi_len_i = 6'd5; settle();
    check_eq("t2_c0", {26'd0, stall_o}, 32'h0000_000f);
    tick(1'b1);
    ex_multi_start_i = 1'b0; ex_multi_len_i = 6'd0;
    for (int i = 1; i <= 3; i++) begin
      settle();
      check_eq($sformatf("t2_c%0d", i), {26'd0, stall_o}, 32'h0000_000f);
      tick(1'b1);
    end
    settle();
    check_eq("t2_done", {26'd0, stall_o}, 32'h0000_0000);
    check_eq("t2_sc", stall_cycles_o, exp_sc);
    tick(1'b0);

    // L=2: one stall cycle, stays IDLE
    ex_multi_start_i = 1'b1; ex_multi_len_i = 6'd2; settle();
    check_eq("l2_c0", {26'd0, stall_o}, 32'h0000_000f);
    tick(1'b1);
    ex_multi_start_i = 1'b0; settle();
    check_eq("l2_c1", {26'd0, stall_o}, 32'h0000_0000);
    tick(1'b0);
    // L=1: no stall at all
    ex_multi_start_i = 1'b1; ex_multi_len_i = 6'd1; settle();
    check_eq("l1_c0", {26'd0, stall_o}, 32'h0000_0000);
    tick(1'b0);
    ex_multi_start_i = 1'b0; settle();
    check_eq("l1_c1", {26'd0, stall_o}, 32'h0000_0000);
    tick(1'b0);

    // 3: exception held two cycles; the second is ignored in FLUSH
    excepttype_i = 32'h8; settle();
    check_eq("t3_stall", {26'd0, stall_o}, 32'h0000_003f);
    tick(1'b1);
    settle();
    check_eq("t3_flush", {31'd0, flush_o}, 32'd1);
    check_eq("t3_newpc", new_pc_o, 32'h0000_0020);
    check_eq("t3_stall_fl", {26'd0, stall_o}, 32'h0000_0000);
    tick(1'b0);
    excepttype_i = 32'd0; settle();
    check_eq("t3_flush_off", {31'd0, flush_o}, 32'd0);
    check_eq("t3_newpc_hold", new_pc_o, 32'h0000_0020);
    tick(1'b0);

    // 4: ERET during COUNT aborts the op
    ex_multi_start_i = 1'b1; ex_multi_len_i = 6'd5; settle();
    tick(1'b1);
    ex_multi_start_i = 1'b0; excepttype_i = 32'he; cp0_epc_i = 32'h0000_1234; settle();
    check_eq("t4_stall", {26'd0, stall_o}, 32'h0000_003f);
    tick(1'b1);
    excepttype_i = 32'd0; settle();
    check_eq("t4_flush", {31'd0, flush_o}, 32'd1);
    check_eq("t4_newpc", new_pc_o, 32'h0000_1234);
    tick(1'b0);
    settle();
    check_eq("t4_after", {26'd0, stall_o}, 32'h0000_0000);
    check_eq("t4_flush_off", {31'd0, flush_o}, 32'd0);
    tick(1'b0);

    // exception together with a multi-cycle start: no COUNT
    excepttype_i = 32'h4; ex_multi_start_i = 1'b1; ex_multi_len_i = 6'd5; settle();
    check_eq("xs_stall", {26'd0, stall_o}, 32'h0000_003f);
    tick(1'b1);
    excepttype_i = 32'd0; ex_multi_start_i = 1'b0; settle();
    check_eq("xs_flush", {31'd0, flush_o}, 32'd1);
    check_eq("xs_newpc", new_pc_o, 32'h0000_0020);
    tick(1'b0);
    settle();
    check_eq("xs_nocount", {26'd0, stall_o}, 32'h0000_0000);
    check_eq("xs_sc", stall_cycles_o, exp_sc);
    tick(1'b0);

    // 5: MEM beats ID, then reset in the middle of a long op
    stallreq_from_mem = 1'b1; stallreq_from_id = 1'b1; settle();
    check_eq("t5_memid", {26'd0, stall_o}, 32'h0000_001f);
    tick(1'b1);
    idle_inputs();
    ex_multi_start_i = 1'b1; ex_multi_len_i = 6'd10; settle();
    tick(1'b1);
    ex_multi_start_i = 1'b0; settle();
    check_eq("t5_count", {26'd0, stall_o}, 32'h0000_000f);
    tick(1'b1);
    rst = 1'b1; stallreq_from_id = 1'b1; settle();
    check_eq("t5_rst_gate", {26'd0, stall_o}, 32'h0000_0000);
    @(posedge clk); #1;
    exp_sc = 32'd0;
    settle();
    check_eq("t5_rst_flush", {31'd0, flush_o}, 32'd0);
    check_eq("t5_rst_newpc", new_pc_o, 32'd0);
    check_eq("t5_rst_sc", stall_cycles_o, 32'd0);
    rst = 1'b0; stallreq_from_id = 1'b0; settle();
    check_eq("t5_post_rst", {26'd0, stall_o}, 32'h0000_0000);
    tick(1'b0);
    settle();
    check_eq("t5_post_rst2", {26'd0, stall_o}, 32'h0000_0000);
    check_eq("t5_post_flush", {31'd0, flush_o}, 32'd0);

    // 6: saturation of the stall-cycle counter
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    exp_sc = 32'hFFFF_FFFD;
    stallreq_from_mem = 1'b1; settle();
    check_eq("t6_pre", stall_cycles_o, exp_sc);
    for (int i = 0; i < 4; i++) begin
      tick(1'b1);
      settle();
      check_eq($sformatf("t6_sat%0d", i), stall_cycles_o, exp_sc);
    end
    check_eq("t6_max", stall_cycles_o, 32'hFFFF_FFFF);
    idle_inputs();
    tick(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
